// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for one side of the 128-bit line-memory port.
// The master modport drives a request; the slave modport accepts it and answers.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int STRB_W = DATA_W / 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-memory port between the I-cache (m0) and D-cache (m1) refill masters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m1 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master mem,
  output logic               busy_o,
  output logic               owner_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              owner_q;
  logic              winner;
  logic              gnt_now;
  logic              rsp_now;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // On a conflict the master not served last wins; a lone requester always wins.
  always_comb begin
    winner = m1.req;
    if (m0.req && m1.req) winner = ~last_q;
  end
`else
  always_comb begin
    winner = m1.req;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0.req || m1.req) begin
            state   <= REQ;
            req_q   <= 1'b1;
            owner_q <= winner;
            we_q    <= winner ? m1.we    : m0.we;
            addr_q  <= winner ? m1.addr  : m0.addr;
            wdata_q <= winner ? m1.wdata : m0.wdata;
            wstrb_q <= winner ? m1.wstrb : m0.wstrb;
`ifdef MEM_ARB_RR_EN
            last_q  <= winner;
`endif
          end
        end
        REQ: begin
          if (mem.gnt) begin
            req_q <= 1'b0;
            state <= mem.rvalid ? IDLE : RESP;
          end
        end
        RESP: begin
          if (mem.rvalid) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant and response are passed through in the cycle memory signals them,
  // and suppressed while reset is asserted so an abandoned transfer never answers.
  assign gnt_now = rst_ni && (state == REQ) && mem.gnt;
  assign rsp_now = rst_ni && mem.rvalid && (((state == REQ) && mem.gnt) || (state == RESP));

  assign m0.gnt    = gnt_now && !owner_q;
  assign m1.gnt    = gnt_now &&  owner_q;
  assign m0.rvalid = rsp_now && !owner_q;
  assign m1.rvalid = rsp_now &&  owner_q;
  assign m0.rdata  = mem.rdata;
  assign m1.rdata  = mem.rdata;

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.wstrb = wstrb_q;

  assign busy_o  = (state != IDLE);
  assign owner_o = owner_q;

endmodule
